// File: rtl/ultra_pkg.sv
// ultra_pkg: shared FSM states and conversion constants for the ultrasonic ranger
package ultra_pkg;
  typedef enum logic [2:0] {IDLE, TRIG, WAIT_RISE, MEASURE, DONE, FAIL} state_t;
  localparam int US_PER_CM = 58;
  localparam int DIST_W = 9;
endpackage

// File: rtl/us_tick_gen.sv
// us_tick_gen: free-running 1 us prescaler (clk, rst active-low async, tick 1-cycle pulse)
module us_tick_gen #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);
  localparam int DIV = CLK_HZ / 1_000_000;
  localparam int W = DIV > 1 ? $clog2(DIV) : 1;
  logic [W-1:0] cnt_q;
  logic tick_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= (cnt_q == W'(DIV - 1)) ? '0 : cnt_q + 1'b1;
      tick_q <= cnt_q == W'(DIV - 1);
    end
  assign tick = tick_q;
endmodule

// File: rtl/ultrasonic_ranger.sv
// ultrasonic_ranger: HC-SR04 trigger/echo timer with cm conversion and hysteretic near flag
// ports: clk, rst (async active-low), echo (async in), trig, dist_cm, dist_valid, timeout, near, led
module ultrasonic_ranger
  import ultra_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int TRIG_US    = 10,
  parameter int PERIOD_MS  = 60,
  parameter int TIMEOUT_US = 25000,
  parameter int NEAR_CM    = 10,
  parameter int HYST_CM    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              echo,
  output logic              trig,
  output logic [DIST_W-1:0] dist_cm,
  output logic              dist_valid,
  output logic              timeout,
  output logic              near,
  output logic              led
);
  localparam int PERIOD_US = PERIOD_MS * 1000;
  localparam int PW = $clog2(PERIOD_US + 1);
  localparam int CW = $clog2((TIMEOUT_US > TRIG_US ? TIMEOUT_US : TRIG_US) + 1);
  localparam int SW = $clog2(US_PER_CM);
  logic tick;
  state_t state_q, state_d;
  logic [PW-1:0] per_q, per_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] sub_q, sub_d;
  logic [DIST_W-1:0] cm_q, cm_d, dist_q, dist_d;
  logic started_q, started_d, stale_q, stale_d, near_q, near_d;
  logic dv_q, dv_d, to_q, to_d;
  logic s1_q, s2_q, s3_q, rise_q, fall_q;
  us_tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (.clk(clk), .rst(rst), .tick(tick));
  // s3_q is the echo level aligned with the registered rise/fall events
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      {s1_q, s2_q, s3_q, rise_q, fall_q} <= '0;
    end else begin
      s1_q   <= echo;
      s2_q   <= s1_q;
      s3_q   <= s2_q;
      rise_q <= s2_q & ~s3_q;
      fall_q <= ~s2_q & s3_q;
    end
  always_comb begin
    state_d   = state_q;
    per_d     = (tick && per_q != PW'(PERIOD_US)) ? per_q + 1'b1 : per_q;
    cnt_d     = tick ? cnt_q + 1'b1 : cnt_q;
    sub_d     = sub_q;
    cm_d      = cm_q;
    started_d = started_q;
    stale_d   = stale_q;
    dist_d    = dist_q;
    near_d    = near_q;
    dv_d      = 1'b0;
    to_d      = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        // the very first trigger after reset does not wait for a full period
        if (tick && (!started_q || per_q >= PW'(PERIOD_US - 1))) begin
          state_d   = TRIG;
          per_d     = '0;
          started_d = 1'b1;
        end
      end
      TRIG:
        if (tick && cnt_q == CW'(TRIG_US - 1)) begin
          state_d = WAIT_RISE;
          cnt_d   = '0;
          stale_d = s3_q;
        end
      WAIT_RISE: begin
        if (fall_q) stale_d = 1'b0;
        if (rise_q && !stale_q) begin
          state_d = MEASURE;
          cnt_d   = '0;
          sub_d   = '0;
          cm_d    = '0;
        end else if (tick && cnt_q == CW'(TIMEOUT_US - 1)) state_d = FAIL;
      end
      MEASURE: begin
        if (tick) begin
          sub_d = (sub_q == SW'(US_PER_CM - 1)) ? '0 : sub_q + 1'b1;
          cm_d  = (sub_q == SW'(US_PER_CM - 1) && cm_q != '1) ? cm_q + 1'b1 : cm_q;
        end
        if (fall_q) state_d = DONE;
        else if (tick && cnt_q == CW'(TIMEOUT_US - 1)) state_d = FAIL;
      end
      DONE: begin
        state_d = IDLE;
        dist_d  = cm_q;
        dv_d    = 1'b1;
        near_d  = cm_q <= DIST_W'(NEAR_CM) ? 1'b1 :
                  cm_q > DIST_W'(NEAR_CM + HYST_CM) ? 1'b0 : near_q;
      end
      FAIL: begin
        state_d = IDLE;
        to_d    = 1'b1;
        near_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q   <= IDLE;
      per_q     <= '0;
      cnt_q     <= '0;
      sub_q     <= '0;
      cm_q      <= '0;
      dist_q    <= '0;
      started_q <= 1'b0;
      stale_q   <= 1'b0;
      near_q    <= 1'b0;
      dv_q      <= 1'b0;
      to_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      per_q     <= per_d;
      cnt_q     <= cnt_d;
      sub_q     <= sub_d;
      cm_q      <= cm_d;
      dist_q    <= dist_d;
      started_q <= started_d;
      stale_q   <= stale_d;
      near_q    <= near_d;
      dv_q      <= dv_d;
      to_q      <= to_d;
    end
  // decoded from the async-reset state register so trig drops the moment rst asserts
  assign trig       = state_q == TRIG;
  assign dist_cm    = dist_q;
  assign dist_valid = dv_q;
  assign timeout    = to_q;
  assign near       = near_q;
  assign led        = near_q;
endmodule

// File: tb/tb_ultrasonic_ranger.sv
// tb_ultrasonic_ranger: scoreboard bench for ultrasonic_ranger at 1 clk per us
module tb_ultrasonic_ranger;
  typedef struct {
    bit         is_to;
    logic [8:0] d;
    bit         n;
  } exp_t;
  logic clk = 1'b0, rst = 1'b0, echo = 1'b0;
  logic trig, dist_valid, timeout, near, led;
  logic [8:0] dist_cm;
  int n_chk = 0, n_fail = 0, cyc = 0;
  exp_t sb[$];
  ultrasonic_ranger #(
    .CLK_HZ(1_000_000), .TRIG_US(10), .PERIOD_MS(2), .TIMEOUT_US(1000),
    .NEAR_CM(10), .HYST_CM(2)
  ) dut (
    .clk(clk), .rst(rst), .echo(echo), .trig(trig), .dist_cm(dist_cm),
    .dist_valid(dist_valid), .timeout(timeout), .near(near), .led(led)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  always @(negedge clk)
    if (rst && (dist_valid || timeout)) begin
      if (sb.size() == 0) chk("unexpected_event", {dist_valid, timeout}, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("kind_timeout", timeout, e.is_to);
        chk("kind_valid", dist_valid, !e.is_to);
        chk("dist_cm", dist_cm, e.d);
        chk("near", near, e.n);
        chk("led", led, e.n);
      end
    end
  task automatic push(input bit is_to, input int d, input bit n);
    exp_t e;
    e.is_to = is_to;
    e.d = 9'(d);
    e.n = n;
    sb.push_back(e);
  endtask
  task automatic next_trig(output int rc);
    int n = 0;
    while (!trig && n < 2500) begin
      @(negedge clk);
      n++;
    end
    rc = cyc;
    if (n >= 2500) chk("trig_rise_wait", 0, 1);
    n = 0;
    while (trig && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("trig_fall_wait", 0, 1);
  endtask
  task automatic drive_echo(input int dly, input int width);
    repeat (dly) @(negedge clk);
    echo = 1'b1;
    repeat (width) @(negedge clk);
    echo = 1'b0;
  endtask
  task automatic drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("drain", sb.size(), 0);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int n, w, r1, r2;
    repeat (5) @(negedge clk);
    chk("rst_trig", trig, 0);
    chk("rst_dist", dist_cm, 0);
    chk("rst_near", near, 0);
    chk("rst_valid", dist_valid, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_led", led, 0);
    rst = 1'b1;
    n = 0;
    while (!trig && n < 5) begin
      @(negedge clk);
      n++;
    end
    chk("trig_rise_le2", n >= 1 && n <= 2, 1);
    w = 0;
    while (trig && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("trig_width", w, 10);
    push(0, 10, 1);
    drive_echo(100, 580);
    drain(50);
    next_trig(r1);
    push(0, 12, 1);
    drive_echo(100, 696);
    drain(50);
    next_trig(r1);
    push(0, 13, 0);
    drive_echo(100, 754);
    drain(50);
    next_trig(r1);
    push(1, 13, 0);
    n = 0;
    while (!timeout && n < 1100) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_latency", n >= 1000 && n <= 1002, 1);
    drain(10);
    echo = 1'b1;
    push(1, 13, 0);
    next_trig(r2);
    chk("period_2ms", r2 - r1, 2000);
    drain(1200);
    echo = 1'b0;
    next_trig(r1);
    repeat (100) @(negedge clk);
    echo = 1'b1;
    repeat (300) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("amid_trig", trig, 0);
    chk("amid_dist", dist_cm, 0);
    chk("amid_near", near, 0);
    chk("amid_valid", dist_valid, 0);
    chk("amid_timeout", timeout, 0);
    @(negedge clk);
    echo = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    next_trig(r1);
    push(0, 10, 1);
    drive_echo(100, 580);
    drain(50);
    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
